// File: rtl/ntt_pkg.sv
// Shared NTT arithmetic definitions: field modulus, word type and mod-q helpers.
package ntt_pkg;

  localparam int unsigned WORD_W    = 28;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned N_FACTORS = 16;
  localparam int unsigned MULT_LAT  = 5;

  typedef logic [WORD_W-1:0] word_t;

  // q = 2^28 - 2^16 + 1
  localparam word_t Q = 28'd268369921;

  // First pipeline stage payload of the butterfly
  typedef struct packed {
    word_t sum;
    word_t diff;
    word_t w;
  } s1_t;

  function automatic word_t mod_add(input word_t a, input word_t b);
    logic [WORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[WORD_W-1:0];
  endfunction

  function automatic word_t mod_sub(input word_t a, input word_t b);
    return (a >= b) ? (a - b) : (a - b + Q);
  endfunction

  // Multiply by 2^-1 mod q: odd values are made even by adding q first
  function automatic word_t halve(input word_t a);
    logic [WORD_W:0] t;
    t = a[0] ? ({1'b0, a} + {1'b0, Q}) : {1'b0, a};
    return t[WORD_W:1];
  endfunction

endpackage

// File: rtl/modular_mult.sv
// Pipelined a*b mod q (5 cycles) using the identity 2^28 = 2^16 - 1 (mod q).
module modular_mult
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] p
);

  localparam int unsigned PROD_W = 2 * WORD_W;
  localparam int unsigned F1_W   = 45;
  localparam int unsigned F2_W   = 34;
  localparam int unsigned F3_W   = 29;

  logic [PROD_W-1:0] prod_q;
  logic [F1_W-1:0]   f1_q, f1_c;
  logic [F2_W-1:0]   f2_q, f2_c;
  logic [F3_W-1:0]   f3_q, f3_c;
  word_t             p_q, p_c;

  // Each fold maps hi*2^28 + lo to hi*(2^16 - 1) + lo; three folds leave a value below 2q
  always_comb begin
    f1_c = 45'({prod_q[PROD_W-1:WORD_W], 16'b0}) - 45'(prod_q[PROD_W-1:WORD_W])
         + 45'(prod_q[WORD_W-1:0]);
    f2_c = 34'({f1_q[F1_W-1:WORD_W], 16'b0}) - 34'(f1_q[F1_W-1:WORD_W])
         + 34'(f1_q[WORD_W-1:0]);
    f3_c = 29'({f2_q[F2_W-1:WORD_W], 16'b0}) - 29'(f2_q[F2_W-1:WORD_W])
         + 29'(f2_q[WORD_W-1:0]);
    p_c  = (f3_q >= 29'(Q)) ? 28'(f3_q - 29'(Q)) : f3_q[WORD_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      f1_q   <= '0;
      f2_q   <= '0;
      f3_q   <= '0;
      p_q    <= '0;
    end else begin
      prod_q <= 56'(a) * 56'(b);
      f1_q   <= f1_c;
      f2_q   <= f2_c;
      f3_q   <= f3_c;
      p_q    <= p_c;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/gs_butterfly.sv
// Gentleman-Sande inverse-NTT butterfly: x'=(x+y)h, y'=(x-y)w h mod q, 7-cycle pipeline.
module gs_butterfly
  import ntt_pkg::*;
#(
  parameter logic [CNT_W-1:0] START = 8'd6,
  parameter word_t FACTORS [N_FACTORS] = '{28'd1, 28'd1, 28'd1, 28'd1, 28'd1, 28'd1, 28'd1, 28'd1,
                                           28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0},
  parameter bit HALVE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] x_in,
  input  logic [WORD_W-1:0] y_in,
  output logic              out_valid,
  output logic [WORD_W-1:0] x_out,
  output logic [WORD_W-1:0] y_out
);

  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic                sched_on_c;
  word_t               w_c;
  s1_t                 s1_q;
  logic                v1_q;
  word_t               prod_c;
  logic [MULT_LAT-1:0] vd_q;
  word_t               sd_q [MULT_LAT];
  word_t               x_fin_c, y_fin_c;

  // Twiddle stays on FACTORS[0] until START beats have been accepted
  assign sched_on_c = (cnt_q >= START);
  assign w_c        = sched_on_c ? FACTORS[idx_q] : FACTORS[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (in_valid) begin
      if (sched_on_c) idx_q <= idx_q + 4'd1;
      else            cnt_q <= cnt_q + 8'd1;
    end
  end

  // Stage 1: sum, difference and twiddle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        s1_q.sum  <= mod_add(x_in, y_in);
        s1_q.diff <= mod_sub(x_in, y_in);
        s1_q.w    <= w_c;
      end
    end
  end

  modular_mult u_mult (
    .clk (clk),
    .rst (~rst),
    .a   (s1_q.diff),
    .b   (s1_q.w),
    .p   (prod_c)
  );

  // Sum and valid ride alongside the multiplier
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vd_q <= '0;
      for (int i = 0; i < int'(MULT_LAT); i++) sd_q[i] <= '0;
    end else begin
      vd_q    <= {vd_q[MULT_LAT-2:0], v1_q};
      sd_q[0] <= s1_q.sum;
      for (int i = 1; i < int'(MULT_LAT); i++) sd_q[i] <= sd_q[i-1];
    end
  end

  assign x_fin_c = HALVE ? halve(sd_q[MULT_LAT-1]) : sd_q[MULT_LAT-1];
  assign y_fin_c = HALVE ? halve(prod_c) : prod_c;

  // Stage 7: results update only with a valid beat, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      out_valid <= vd_q[MULT_LAT-1];
      if (vd_q[MULT_LAT-1]) begin
        x_out <= x_fin_c;
        y_out <= y_fin_c;
      end
    end
  end

endmodule

// File: tb/tb_gs_butterfly.sv
// Bench for gs_butterfly: two configurations against a plain-arithmetic mod-q reference.
module tb_gs_butterfly;
  import ntt_pkg::*;

  localparam longint unsigned QM   = 64'd268369921;
  localparam longint unsigned INV2 = 64'd134184961;
  localparam int unsigned START_A = 2;
  localparam int unsigned START_B = 0;
  localparam word_t FA [16] = '{28'd1, 28'd2, 28'd3, 28'd4, 28'd5, 28'd6, 28'd7, 28'd8,
                                28'd9, 28'd10, 28'd11, 28'd12, 28'd13, 28'd14, 28'd15, 28'd16};
  localparam word_t FB [16] = '{28'd1, 28'd268369920, 28'd17, 28'd200000000,
                                28'd99999989, 28'd3, 28'd134184961, 28'd65536,
                                28'd12345678, 28'd250000001, 28'd7, 28'd160000003,
                                28'd42, 28'd268300000, 28'd5, 28'd77777777};

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid;
  word_t x_in, y_in;
  logic  ov_a, ov_b;
  word_t xa, ya, xb, yb;

  gs_butterfly #(.START(8'd2), .FACTORS(FA), .HALVE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
    .out_valid(ov_a), .x_out(xa), .y_out(ya)
  );

  gs_butterfly #(.START(8'd0), .FACTORS(FB), .HALVE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
    .out_valid(ov_b), .x_out(xb), .y_out(yb)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  int unsigned     nb [2];
  logic            ev [2][8];
  longint unsigned ex [2][8];
  longint unsigned ey [2][8];
  longint unsigned lx [2];
  longint unsigned ly [2];

  function automatic longint unsigned twiddle(input int inst, input int unsigned n);
    int unsigned st;
    int unsigned k;
    st = (inst == 0) ? START_A : START_B;
    k  = (n <= st) ? 0 : (n - st) % 16;
    return (inst == 0) ? 64'(FA[k]) : 64'(FB[k]);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0;
      lx[i] = 0;
      ly[i] = 0;
      for (int j = 0; j < 8; j++) ev[i][j] = 1'b0;
    end
  endfunction

  function automatic word_t rand_word();
    int unsigned r;
    r = $urandom_range(7, 0);
    if (r == 0) return '0;
    if (r == 1) return Q - 28'd1;
    return 28'($urandom_range(268369920, 0));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_outputs();
    int slot;
    slot = cyc % 8;
    for (int i = 0; i < 2; i++) begin
      if (ev[i][slot]) begin
        lx[i] = ex[i][slot];
        ly[i] = ey[i][slot];
      end
    end
    chk("a.out_valid", 64'(ov_a), 64'(ev[0][slot]));
    chk("a.x_out",     64'(xa),   lx[0]);
    chk("a.y_out",     64'(ya),   ly[0]);
    chk("b.out_valid", 64'(ov_b), 64'(ev[1][slot]));
    chk("b.x_out",     64'(xb),   lx[1]);
    chk("b.y_out",     64'(yb),   ly[1]);
  endtask

  task automatic check_zero(input string when);
    chk({when, " a.out_valid"}, 64'(ov_a), 64'd0);
    chk({when, " a.x_out"},     64'(xa),   64'd0);
    chk({when, " a.y_out"},     64'(ya),   64'd0);
    chk({when, " b.out_valid"}, 64'(ov_b), 64'd0);
    chk({when, " b.x_out"},     64'(xb),   64'd0);
    chk({when, " b.y_out"},     64'(yb),   64'd0);
  endtask

  // One cycle: check what is on the outputs now, drive a beat, predict its result 7 cycles on
  task automatic step(input logic v, input word_t x, input word_t y);
    longint unsigned xl, yl, s, d, w, h;
    int slot;
    check_outputs();
    in_valid = v;
    x_in     = x;
    y_in     = y;
    xl = 64'(x);
    yl = 64'(y);
    slot = (cyc + 7) % 8;
    for (int i = 0; i < 2; i++) begin
      ev[i][slot] = v;
      if (v) begin
        s = (xl + yl) % QM;
        d = (xl + QM - yl) % QM;
        w = twiddle(i, nb[i]);
        h = (i == 0) ? 64'd1 : INV2;
        ex[i][slot] = (s * h) % QM;
        ey[i][slot] = (((d * w) % QM) * h) % QM;
        nb[i]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    x_in     = '0;
    y_in     = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    // Directed arithmetic, including wrap-around of add and subtract
    step(1'b1, 28'd5, 28'd3);
    step(1'b1, Q - 28'd1, 28'd2);
    step(1'b1, 28'd1, 28'd2);
    step(1'b1, 28'd1, 28'd0);
    step(1'b1, 28'd4, 28'd2);

    // Bubble pattern 1,0,0,1,1
    step(1'b1, rand_word(), rand_word());
    step(1'b0, rand_word(), rand_word());
    step(1'b0, rand_word(), rand_word());
    step(1'b1, rand_word(), rand_word());
    step(1'b1, rand_word(), rand_word());

    for (int i = 0; i < 40; i++) step($urandom_range(3, 0) != 0, rand_word(), rand_word());

    // Reset with four beats in flight: outputs must clear without a clock edge
    for (int i = 0; i < 4; i++) step(1'b1, rand_word(), rand_word());
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_zero("async reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();

    // Schedule restarts from beat 0: twiddle walk with x=0, y=1
    for (int i = 0; i < 20; i++) step(1'b1, 28'd0, 28'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 28'd0, 28'd0);

    for (int i = 0; i < 60; i++) step($urandom_range(3, 0) != 0, rand_word(), rand_word());
    for (int i = 0; i < 9; i++) step(1'b0, 28'd0, 28'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
